core_c1_sb_arbiter: RTL and testbench

//  2-master -> 1-slave system-bus arbiter between core_c1 BIU master ports (m0 = IFU fetch, m1 = LSU) and the single SoC bus slave port.

---
 rtl/core_c1_sb_arbiter_pkg.sv | 16 +
 rtl/core_c1_sb_arbiter_if.sv | 32 +++
 rtl/core_c1_sb_id_fifo.sv | 54 +++++
 rtl/core_c1_sb_arbiter.sv | 134 +++++++++++++
 tb/tb_core_c1_sb_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_c1_sb_arbiter_pkg.sv
// Shared constants for the core_c1 system-bus arbiter slice.
// Contents: arbitration mode codes, master IDs and bus field widths.
// Imported by the interface, the ID FIFO and the arbiter top.
package core_c1_sb_pkg;

    localparam int ARB_FIXED = 0;   // m1 always wins a tie
    localparam int ARB_RR    = 1;   // alternate after each accepted request

    localparam logic MST_M0 = 1'b0; // IFU fetch port
    localparam logic MST_M1 = 1'b1; // LSU port

    localparam int SB_AW = 32;
    localparam int SB_DW = 32;
    localparam int SB_SW = 4;

endpackage

// File: rtl/core_c1_sb_arbiter_if.sv
// One system-bus port: AR/R read channels and W/B write channels.
// master modport drives requests and response readies; slave modport drives
// request readies and responses.
interface core_c1_sb_arbiter_if;
    import core_c1_sb_pkg::*;

    logic             arvalid;
    logic [SB_AW-1:0] araddr;
    logic             arready;
    logic             rvalid;
    logic [SB_DW-1:0] rdata;
    logic             rready;
    logic             wvalid;
    logic [SB_AW-1:0] waddr;
    logic [SB_DW-1:0] wdata;
    logic [SB_SW-1:0] wstrb;
    logic             wready;
    logic             bvalid;
    logic             bresp;
    logic             bready;

    modport master (
        output arvalid, araddr, rready, wvalid, waddr, wdata, wstrb, bready,
        input  arready, rvalid, rdata, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready, wvalid, waddr, wdata, wstrb, bready,
        output arready, rvalid, rdata, wready, bvalid, bresp
    );

endinterface

// File: rtl/core_c1_sb_id_fifo.sv
// In-order FIFO of 1-bit master IDs for outstanding transactions.
// Ports: push/din write, pop read, full/empty status, head = oldest ID.
// Push is ignored while full, pop ignored while empty; push+pop together keep the count.
module core_c1_sb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/core_c1_sb_arbiter.sv
// 2-master -> 1-slave system-bus arbiter (m0 = IFU, m1 = LSU); AR and W arbitrated independently.
// Ports: clk/rst_n, m0/m1 master-facing ports, s slave-facing port, rsp_err sticky error.
// Zero-latency request and response paths; a granted request is held until the slave accepts it.
module core_c1_sb_arbiter
    import core_c1_sb_pkg::*;
#(
    parameter int OUTST_DEPTH = 4,
    parameter int ARB_MODE    = ARB_FIXED
) (
    input  logic                        clk,
    input  logic                        rst_n,
    core_c1_sb_arbiter_if.slave         m0,
    core_c1_sb_arbiter_if.slave         m1,
    core_c1_sb_arbiter_if.master        s,
    output logic                        rsp_err
);

    // Grant for one request channel; a held lock overrides arbitration.
    function automatic logic arb_pick(input logic [1:0] req, input logic lock,
                                      input logic lock_id, input logic rr_ptr);
        logic g;
        if (lock)
            g = lock_id;
        else if (ARB_MODE == ARB_RR && req == 2'b11)
            g = rr_ptr;
        else
            g = req[1] ? MST_M1 : MST_M0;
        return g;
    endfunction

    // Channel index 0 = AR, 1 = W.
    logic [1:0] ch_req [2];
    logic [1:0] ch_full;
    logic [1:0] ch_rdy;
    logic [1:0] ch_gnt;
    logic [1:0] ch_vld;
    logic [1:0] ch_hs;

    logic rd_full, rd_empty, rd_head, rd_pop, rd_rready;
    logic wr_full, wr_empty, wr_head, wr_pop, wr_bready;

    assign ch_req[0] = {m1.arvalid, m0.arvalid};
    assign ch_req[1] = {m1.wvalid,  m0.wvalid};
    assign ch_full   = {wr_full, rd_full};
    assign ch_rdy    = {s.wready, s.arready};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic lock_q;
        logic lock_id_q;
        logic rr_q;

        assign ch_gnt[c] = arb_pick(ch_req[c], lock_q, lock_id_q, rr_q);
        // full gates the request even when a response pops in the same cycle
        assign ch_vld[c] = (|ch_req[c]) & ~ch_full[c];
        assign ch_hs[c]  = (|ch_req[c]) & ~ch_full[c] & ch_rdy[c];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lock_q    <= 1'b0;
                lock_id_q <= MST_M0;
                rr_q      <= MST_M1;
            end else if (ch_hs[c]) begin
                lock_q <= 1'b0;
                rr_q   <= ~ch_gnt[c];
            end else if (ch_vld[c]) begin
                // offered but not taken: pin this master until the slave accepts
                lock_q    <= 1'b1;
                lock_id_q <= ch_gnt[c];
            end
        end
    end

    // AR request path
    assign s.arvalid  = ch_vld[0];
    assign s.araddr   = ch_gnt[0] ? m1.araddr : m0.araddr;
    assign m0.arready = (ch_gnt[0] == MST_M0) & s.arready & ~rd_full;
    assign m1.arready = (ch_gnt[0] == MST_M1) & s.arready & ~rd_full;

    // W request path
    assign s.wvalid  = ch_vld[1];
    assign s.waddr   = ch_gnt[1] ? m1.waddr : m0.waddr;
    assign s.wdata   = ch_gnt[1] ? m1.wdata : m0.wdata;
    assign s.wstrb   = ch_gnt[1] ? m1.wstrb : m0.wstrb;
    assign m0.wready = (ch_gnt[1] == MST_M0) & s.wready & ~wr_full;
    assign m1.wready = (ch_gnt[1] == MST_M1) & s.wready & ~wr_full;

    core_c1_sb_id_fifo #(.DEPTH(OUTST_DEPTH)) u_rd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ch_hs[0]),
        .din   (ch_gnt[0]),
        .pop   (rd_pop),
        .full  (rd_full),
        .empty (rd_empty),
        .head  (rd_head)
    );

    core_c1_sb_id_fifo #(.DEPTH(OUTST_DEPTH)) u_wr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ch_hs[1]),
        .din   (ch_gnt[1]),
        .pop   (wr_pop),
        .full  (wr_full),
        .empty (wr_empty),
        .head  (wr_head)
    );

    // R response path: drain unconditionally while nothing is outstanding
    assign rd_rready = rd_empty ? 1'b1 : (rd_head ? m1.rready : m0.rready);
    assign rd_pop    = s.rvalid & rd_rready & ~rd_empty;
    assign s.rready  = rd_rready;
    assign m0.rvalid = s.rvalid & ~rd_empty & (rd_head == MST_M0);
    assign m1.rvalid = s.rvalid & ~rd_empty & (rd_head == MST_M1);
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;

    // B response path
    assign wr_bready = wr_empty ? 1'b1 : (wr_head ? m1.bready : m0.bready);
    assign wr_pop    = s.bvalid & wr_bready & ~wr_empty;
    assign s.bready  = wr_bready;
    assign m0.bvalid = s.bvalid & ~wr_empty & (wr_head == MST_M0);
    assign m1.bvalid = s.bvalid & ~wr_empty & (wr_head == MST_M1);
    assign m0.bresp  = s.bresp;
    assign m1.bresp  = s.bresp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_err <= 1'b0;
        else if ((s.rvalid & rd_empty) | (s.bvalid & wr_empty))
            rsp_err <= 1'b1;
    end

endmodule

// File: tb/tb_core_c1_sb_arbiter.sv
// Directed self-checking bench for core_c1_sb_arbiter (fixed-priority and round-robin instances).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Prints one TB_RESULT summary line.
module tb_core_c1_sb_arbiter;
    import core_c1_sb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rsp_err;
    logic rsp_err_rr;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    core_c1_sb_arbiter_if m0_if ();
    core_c1_sb_arbiter_if m1_if ();
    core_c1_sb_arbiter_if s_if ();
    core_c1_sb_arbiter_if r0_if ();
    core_c1_sb_arbiter_if r1_if ();
    core_c1_sb_arbiter_if rs_if ();

    core_c1_sb_arbiter #(.OUTST_DEPTH(4), .ARB_MODE(ARB_FIXED)) u_dut (
        .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if), .rsp_err(rsp_err)
    );

    core_c1_sb_arbiter #(.OUTST_DEPTH(4), .ARB_MODE(ARB_RR)) u_dut_rr (
        .clk(clk), .rst_n(rst_n), .m0(r0_if), .m1(r1_if), .s(rs_if), .rsp_err(rsp_err_rr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.rready = 1; m0_if.wvalid = 0;
        m0_if.waddr = '0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.bready = 1;
        m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.rready = 1; m1_if.wvalid = 0;
        m1_if.waddr = '0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.bready = 1;
        s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = '0;
        s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = 0;
        r0_if.arvalid = 0; r0_if.araddr = '0; r0_if.rready = 1; r0_if.wvalid = 0;
        r0_if.waddr = '0; r0_if.wdata = '0; r0_if.wstrb = '0; r0_if.bready = 1;
        r1_if.arvalid = 0; r1_if.araddr = '0; r1_if.rready = 1; r1_if.wvalid = 0;
        r1_if.waddr = '0; r1_if.wdata = '0; r1_if.wstrb = '0; r1_if.bready = 1;
        rs_if.arready = 0; rs_if.rvalid = 0; rs_if.rdata = '0;
        rs_if.wready = 0; rs_if.bvalid = 0; rs_if.bresp = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_inputs();
        @(negedge clk);
        checks++;
        if ({s_if.arvalid, s_if.wvalid, s_if.rready, s_if.bready} !== 4'b0011) begin
            failures++;
            $display("FAIL reset_slave_hs got=%b exp=0011", {s_if.arvalid, s_if.wvalid, s_if.rready, s_if.bready});
        end
        checks++;
        if ({m0_if.arready, m1_if.arready, m0_if.wready, m1_if.wready,
             m0_if.rvalid, m1_if.rvalid, m0_if.bvalid, m1_if.bvalid} !== 8'h00) begin
            failures++;
            $display("FAIL reset_master_hs got=%b exp=00000000", {m0_if.arready, m1_if.arready, m0_if.wready,
                     m1_if.wready, m0_if.rvalid, m1_if.rvalid, m0_if.bvalid, m1_if.bvalid});
        end
        checks++;
        if ({rsp_err, rsp_err_rr} !== 2'b00) begin
            failures++;
            $display("FAIL reset_rsp_err got=%b exp=00", {rsp_err, rsp_err_rr});
        end
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_read_route();
        m0_if.arvalid = 1; m0_if.araddr = 32'h100; s_if.arready = 1;
        @(negedge clk);
        checks++;
        if ({s_if.arvalid, s_if.araddr, m0_if.arready} !== {1'b1, 32'h100, 1'b1}) begin
            failures++;
            $display("FAIL rd_req got=%b/%h/%b exp=1/00000100/1", s_if.arvalid, s_if.araddr, m0_if.arready);
        end
        cyc();
        m0_if.arvalid = 0; s_if.arready = 0; m0_if.rready = 0;
        @(negedge clk);
        // outstanding m0 read with m0 not ready: no longer in drain mode
        checks++;
        if (s_if.rready !== 1'b0) begin
            failures++;
            $display("FAIL rd_outstanding_rready got=%b exp=0", s_if.rready);
        end
        cyc();
        m0_if.rready = 1; s_if.rvalid = 1; s_if.rdata = 32'hDEAD;
        @(negedge clk);
        checks++;
        if ({m0_if.rvalid, m1_if.rvalid, m0_if.rdata, s_if.rready} !== {2'b10, 32'hDEAD, 1'b1}) begin
            failures++;
            $display("FAIL rd_route got=%b%b/%h/%b exp=10/0000dead/1", m0_if.rvalid, m1_if.rvalid, m0_if.rdata, s_if.rready);
        end
        cyc();
        s_if.rvalid = 0;
        @(negedge clk);
        checks++;
        if (rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_no_err got=%b exp=0", rsp_err);
        end
        cyc();
    endtask

    task automatic test_fixed_prio();
        m0_if.arvalid = 1; m0_if.araddr = 32'h10;
        m1_if.arvalid = 1; m1_if.araddr = 32'h20; s_if.arready = 1;
        @(negedge clk);
        checks++;
        if ({s_if.araddr, m0_if.arready, m1_if.arready} !== {32'h20, 2'b01}) begin
            failures++;
            $display("FAIL fixed_first got=%h/%b%b exp=00000020/01", s_if.araddr, m0_if.arready, m1_if.arready);
        end
        cyc();
        m1_if.arvalid = 0;
        @(negedge clk);
        checks++;
        if ({s_if.araddr, m0_if.arready, m1_if.arready} !== {32'h10, 2'b10}) begin
            failures++;
            $display("FAIL fixed_second got=%h/%b%b exp=00000010/10", s_if.araddr, m0_if.arready, m1_if.arready);
        end
        cyc();
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rdata = 32'hA1;
        @(negedge clk);
        checks++;
        if ({m0_if.rvalid, m1_if.rvalid} !== 2'b01) begin
            failures++;
            $display("FAIL fixed_r1 got=%b%b exp=01", m0_if.rvalid, m1_if.rvalid);
        end
        cyc();
        s_if.rdata = 32'hA2;
        @(negedge clk);
        checks++;
        if ({m0_if.rvalid, m1_if.rvalid} !== 2'b10) begin
            failures++;
            $display("FAIL fixed_r2 got=%b%b exp=10", m0_if.rvalid, m1_if.rvalid);
        end
        cyc();
        s_if.rvalid = 0;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h40; exp_addr[1] = 32'h30; exp_addr[2] = 32'h40; exp_addr[3] = 32'h30;
        r0_if.arvalid = 1; r0_if.araddr = 32'h30;
        r1_if.arvalid = 1; r1_if.araddr = 32'h40; rs_if.arready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({rs_if.arvalid, rs_if.araddr} !== {1'b1, exp_addr[i]}) begin
                failures++;
                $display("FAIL rr_grant_%0d got=%b/%h exp=1/%h", i, rs_if.arvalid, rs_if.araddr, exp_addr[i]);
            end
            cyc();
        end
        r0_if.arvalid = 0; r1_if.arvalid = 0; rs_if.arready = 0;
    endtask

    task automatic test_lock();
        m0_if.arvalid = 1; m0_if.araddr = 32'h300; s_if.arready = 0;
        @(negedge clk);
        checks++;
        if ({s_if.arvalid, s_if.araddr} !== {1'b1, 32'h300}) begin
            failures++;
            $display("FAIL lock_offer got=%b/%h exp=1/00000300", s_if.arvalid, s_if.araddr);
        end
        cyc();
        m1_if.arvalid = 1; m1_if.araddr = 32'h400;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({s_if.arvalid, s_if.araddr} !== {1'b1, 32'h300}) begin
                failures++;
                $display("FAIL lock_hold_%0d got=%b/%h exp=1/00000300", i, s_if.arvalid, s_if.araddr);
            end
            cyc();
        end
        s_if.arready = 1;
        @(negedge clk);
        checks++;
        if ({s_if.araddr, m0_if.arready, m1_if.arready} !== {32'h300, 2'b10}) begin
            failures++;
            $display("FAIL lock_accept got=%h/%b%b exp=00000300/10", s_if.araddr, m0_if.arready, m1_if.arready);
        end
        cyc();
        m0_if.arvalid = 0;
        @(negedge clk);
        checks++;
        if ({s_if.araddr, m0_if.arready, m1_if.arready} !== {32'h400, 2'b01}) begin
            failures++;
            $display("FAIL lock_next got=%h/%b%b exp=00000400/01", s_if.araddr, m0_if.arready, m1_if.arready);
        end
        cyc();
        m1_if.arvalid = 0; s_if.arready = 0; s_if.rvalid = 1;
        @(negedge clk);
        checks++;
        if ({m0_if.rvalid, m1_if.rvalid} !== 2'b10) begin
            failures++;
            $display("FAIL lock_r0 got=%b%b exp=10", m0_if.rvalid, m1_if.rvalid);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({m0_if.rvalid, m1_if.rvalid} !== 2'b01) begin
            failures++;
            $display("FAIL lock_r1 got=%b%b exp=01", m0_if.rvalid, m1_if.rvalid);
        end
        cyc();
        s_if.rvalid = 0;
    endtask

    task automatic test_full();
        logic order [4];
        logic drain [4];
        order[0] = 1; order[1] = 0; order[2] = 1; order[3] = 0;
        drain[0] = 0; drain[1] = 1; drain[2] = 0; drain[3] = 1;
        m0_if.araddr = 32'h500; m1_if.araddr = 32'h600; s_if.arready = 1;
        for (int i = 0; i < 4; i++) begin
            m0_if.arvalid = ~order[i]; m1_if.arvalid = order[i];
            @(negedge clk);
            checks++;
            if ({m0_if.arready, m1_if.arready} !== {~order[i], order[i]}) begin
                failures++;
                $display("FAIL full_fill_%0d got=%b%b exp=%b%b", i, m0_if.arready, m1_if.arready, ~order[i], order[i]);
            end
            cyc();
        end
        m0_if.arvalid = 0; m1_if.arvalid = 1;
        @(negedge clk);
        checks++;
        if ({s_if.arvalid, m1_if.arready} !== 2'b00) begin
            failures++;
            $display("FAIL full_block got=%b%b exp=00", s_if.arvalid, m1_if.arready);
        end
        cyc();
        s_if.rvalid = 1; s_if.rdata = 32'hB0;
        @(negedge clk);
        checks++;
        if ({s_if.arvalid, m0_if.rvalid, m1_if.rvalid} !== 3'b001) begin
            failures++;
            $display("FAIL full_pop_cycle got=%b/%b%b exp=0/01", s_if.arvalid, m0_if.rvalid, m1_if.rvalid);
        end
        cyc();
        s_if.rvalid = 0;
        @(negedge clk);
        checks++;
        if ({s_if.arvalid, s_if.araddr, m1_if.arready} !== {1'b1, 32'h600, 1'b1}) begin
            failures++;
            $display("FAIL full_fifth got=%b/%h/%b exp=1/00000600/1", s_if.arvalid, s_if.araddr, m1_if.arready);
        end
        cyc();
        m1_if.arvalid = 0; s_if.arready = 0; s_if.rvalid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_if.rvalid, m1_if.rvalid} !== {~drain[i], drain[i]}) begin
                failures++;
                $display("FAIL full_order_%0d got=%b%b exp=%b%b", i, m0_if.rvalid, m1_if.rvalid, ~drain[i], drain[i]);
            end
            cyc();
        end
        s_if.rvalid = 0; m0_if.rready = 0; m1_if.rready = 0;
        @(negedge clk);
        checks++;
        if (s_if.rready !== 1'b1) begin
            failures++;
            $display("FAIL full_drained got=%b exp=1", s_if.rready);
        end
        cyc();
        m0_if.rready = 1; m1_if.rready = 1;
    endtask

    task automatic test_write();
        m1_if.wvalid = 1; m1_if.waddr = 32'h200; m1_if.wdata = 32'h1234_5678;
        m1_if.wstrb = 4'hF; s_if.wready = 1;
        @(negedge clk);
        checks++;
        if ({s_if.wvalid, s_if.waddr, s_if.wdata, s_if.wstrb, m0_if.wready, m1_if.wready}
            !== {1'b1, 32'h200, 32'h1234_5678, 4'hF, 2'b01}) begin
            failures++;
            $display("FAIL wr_req got=%b/%h/%h/%h/%b%b exp=1/00000200/12345678/f/01", s_if.wvalid, s_if.waddr,
                     s_if.wdata, s_if.wstrb, m0_if.wready, m1_if.wready);
        end
        cyc();
        m1_if.wvalid = 0; s_if.wready = 0;
        cyc();
        s_if.bvalid = 1; s_if.bresp = 1;
        @(negedge clk);
        checks++;
        if ({m0_if.bvalid, m1_if.bvalid, m1_if.bresp, s_if.bready} !== 4'b0111) begin
            failures++;
            $display("FAIL wr_bresp got=%b%b/%b/%b exp=01/1/1", m0_if.bvalid, m1_if.bvalid, m1_if.bresp, s_if.bready);
        end
        cyc();
        s_if.bvalid = 0; s_if.bresp = 0; m0_if.bready = 0; m1_if.bready = 0;
        @(negedge clk);
        checks++;
        if ({s_if.bready, rsp_err} !== 2'b10) begin
            failures++;
            $display("FAIL wr_empty_after got=%b%b exp=10", s_if.bready, rsp_err);
        end
        cyc();
        m0_if.bready = 1; m1_if.bready = 1;
    endtask

    task automatic test_err_and_reset();
        s_if.rvalid = 1; s_if.rdata = 32'hBAD;
        @(negedge clk);
        checks++;
        if ({s_if.rready, m0_if.rvalid, m1_if.rvalid} !== 3'b100) begin
            failures++;
            $display("FAIL err_drain got=%b/%b%b exp=1/00", s_if.rready, m0_if.rvalid, m1_if.rvalid);
        end
        cyc();
        s_if.rvalid = 0;
        @(negedge clk);
        checks++;
        if (rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set got=%b exp=1", rsp_err);
        end
        cyc(); cyc(); cyc();
        @(negedge clk);
        checks++;
        if (rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", rsp_err);
        end
        cyc();
        // two reads outstanding, one write stuck behind a busy slave
        m0_if.arvalid = 1; m0_if.araddr = 32'h700; s_if.arready = 1;
        cyc(); cyc();
        m0_if.arvalid = 0; s_if.arready = 0;
        m1_if.wvalid = 1; m1_if.waddr = 32'h800; s_if.wready = 0;
        cyc();
        m0_if.rready = 0; m1_if.rready = 0;
        @(negedge clk);
        checks++;
        if ({s_if.rready, s_if.wvalid, s_if.waddr} !== {2'b01, 32'h800}) begin
            failures++;
            $display("FAIL mid_burst got=%b/%b/%h exp=0/1/00000800", s_if.rready, s_if.wvalid, s_if.waddr);
        end
        m1_if.wvalid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_if.arvalid, s_if.wvalid, s_if.rready, s_if.bready, rsp_err} !== 5'b00110) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=00110", {s_if.arvalid, s_if.wvalid, s_if.rready, s_if.bready, rsp_err});
        end
        cyc(); cyc();
        rst_n = 1'b1; m0_if.rready = 1; m1_if.rready = 1;
        // a stale W lock on m1 would put 0x800 on the bus here
        m0_if.wvalid = 1; m0_if.waddr = 32'h900; s_if.wready = 1;
        @(negedge clk);
        checks++;
        if ({s_if.waddr, m0_if.wready, m1_if.wready} !== {32'h900, 2'b10}) begin
            failures++;
            $display("FAIL reset_lock_clear got=%h/%b%b exp=00000900/10", s_if.waddr, m0_if.wready, m1_if.wready);
        end
        cyc();
        m0_if.wvalid = 0; s_if.wready = 0;
        s_if.rvalid = 1;
        @(negedge clk);
        checks++;
        if ({m0_if.rvalid, m1_if.rvalid, s_if.rready} !== 3'b001) begin
            failures++;
            $display("FAIL stale_r_route got=%b%b/%b exp=00/1", m0_if.rvalid, m1_if.rvalid, s_if.rready);
        end
        cyc();
        s_if.rvalid = 0;
        @(negedge clk);
        checks++;
        if (rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL stale_r_err got=%b exp=1", rsp_err);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_read_route();
        test_fixed_prio();
        test_round_robin();
        test_lock();
        test_full();
        test_write();
        test_err_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
